gcd_driver: RTL and testbench

GCD_DRIVER -- requirements
Module: gcd_driver

---
 rtl/gcd_driver.sv | 120 ++++++++++++
 tb/tb_gcd_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_driver.sv
// Sequencer that hands operand pairs to an external GCD calculator and returns its result.
// Optional abort of a stalled calculation is enabled by defining GCD_DRV_TIMEOUT_EN.
module gcd_driver #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic [7:0] gcd_p,
    output logic [7:0] gcd_q,
    output logic       gcd_start,
    input  logic       gcd_done,
    input  logic [7:0] gcd_r,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_gcd,
    output logic       out_err,
    output logic       busy,
    output logic [1:0] dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid, once raised, stays high with stable data until that transfer.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        WAIT_CLR  = 2'd2,
        OUTPUT    = 2'd3
    } state_t;

    state_t state;

`ifdef GCD_DRV_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt;
    logic       err_q;
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gcd_p     <= 8'd0;
            gcd_q     <= 8'd0;
            gcd_start <= 1'b0;
            out_gcd   <= 8'd0;
            out_valid <= 1'b0;
`ifdef GCD_DRV_TIMEOUT_EN
            to_cnt    <= 8'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        gcd_p <= in_a;
                        gcd_q <= in_b;
                        // A zero operand makes the answer the other operand; skip the calculator.
                        if (in_a == 8'd0 || in_b == 8'd0) begin
                            out_gcd   <= in_a | in_b;
                            out_valid <= 1'b1;
                            state     <= OUTPUT;
`ifdef GCD_DRV_TIMEOUT_EN
                            err_q     <= 1'b0;
`endif
                        end else begin
                            gcd_start <= 1'b1;
                            state     <= WAIT_DONE;
`ifdef GCD_DRV_TIMEOUT_EN
                            to_cnt    <= 8'd0;
`endif
                        end
                    end
                end
                WAIT_DONE: begin
                    if (gcd_done) begin
                        out_gcd   <= gcd_r;
                        gcd_start <= 1'b0;
                        state     <= WAIT_CLR;
`ifdef GCD_DRV_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        out_gcd   <= 8'd0;
                        err_q     <= 1'b1;
                        gcd_start <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end else begin
                        to_cnt    <= to_cnt + 8'd1;
`endif
                    end
                end
                WAIT_CLR: begin
                    // Hold off until the calculator drops done so it cannot be re-launched early.
                    if (!gcd_done) begin
                        out_valid <= 1'b1;
                        state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_driver.sv
// Randomised scoreboard bench for gcd_driver with a behavioural GCD calculator model.
module tb_gcd_driver;

`ifdef GCD_DRV_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b;
    logic [7:0] gcd_p, gcd_q;
    logic       gcd_start;
    logic       gcd_done;
    logic [7:0] gcd_r;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_gcd;
    logic       out_err;
    logic       busy;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] exp_q[$];

    gcd_driver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .gcd_p(gcd_p), .gcd_q(gcd_q),
        .gcd_start(gcd_start), .gcd_done(gcd_done), .gcd_r(gcd_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
        .out_err(out_err), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
        int x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 8'(x);
    endfunction

    // ---------------- calculator model ----------------
    int         calc_phase = 0;
    int         calc_lat;
    int         calc_hold;
    logic       calc_hang = 1'b0;
    logic       prev_start = 1'b0;
    logic [7:0] lat_p, lat_q;

    always @(negedge clk) begin
        if (rst) begin
            calc_phase = 0;
            gcd_done   = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (gcd_start && !prev_start)
                check("relaunch_done_low", {31'd0, gcd_done}, 32'd0);
            prev_start = gcd_start;
            case (calc_phase)
                0: if (gcd_start) begin
                    lat_p      = gcd_p;
                    lat_q      = gcd_q;
                    calc_lat   = $urandom_range(1, 6);
                    calc_phase = 1;
                end
                1: begin
                    check("operands_stable", {16'd0, gcd_p, gcd_q}, {16'd0, lat_p, lat_q});
                    if (!calc_hang) begin
                        calc_lat--;
                        if (calc_lat == 0) begin
                            gcd_done   = 1'b1;
                            gcd_r      = gcd_ref(gcd_p, gcd_q);
                            calc_hold  = $urandom_range(0, 3);
                            calc_phase = 2;
                        end
                    end
                    if (!gcd_start) calc_phase = 0;
                end
                default: if (!gcd_start) begin
                    if (calc_hold == 0) begin
                        gcd_done   = 1'b0;
                        gcd_r      = 8'($urandom_range(0, 255));
                        calc_phase = 0;
                    end else calc_hold--;
                end
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int         hold_left = 0;
    logic       seen = 1'b0;
    logic [8:0] snap;
    logic [8:0] got;

    always @(negedge clk) begin
        if (rst) begin
            seen      = 1'b0;
            out_ready = 1'b0;
        end else if (out_valid) begin
            if (seen) check("output_stable", {23'd0, out_err, out_gcd}, {23'd0, snap});
            else begin
                snap = {out_err, out_gcd};
                seen = 1'b1;
            end
            check("output_flags", {30'd0, in_ready, busy}, 32'd1);
            if (hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else out_ready = 1'($urandom_range(0, 1));
            if (out_ready) begin
                got = {out_err, out_gcd};
                if (exp_q.size() == 0) check("unexpected_output", {23'd0, got}, 32'h1ff);
                else check("result", {23'd0, got}, {23'd0, exp_q.pop_front()});
                seen = 1'b0;
            end
        end else begin
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("accept_timeout", 32'd1, 32'd0);
        if (calc_hang) exp_q.push_back({1'b1, 8'h00});
        else exp_q.push_back({1'b0, gcd_ref(a, b)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 8'($urandom_range(0, 255));
        in_b     = 8'($urandom_range(0, 255));
        if (a == 8'd0 || b == 8'd0) begin
            @(negedge clk);
            check("bypass_valid", {31'd0, out_valid}, 32'd1);
            check("bypass_no_start", {31'd0, gcd_start}, 32'd0);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("drain_timeout", 32'd1, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        logic [7:0] ra, rb;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = 8'd0;
        in_b     = 8'd0;
        gcd_done = 1'b0;
        gcd_r    = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_start", {31'd0, gcd_start}, 32'd0);
        check("rst_operands", {16'd0, gcd_p, gcd_q}, 32'd0);
        check("rst_result", {23'd0, out_err, out_gcd}, 32'd0);

        send(8'd12, 8'd8);
        drain();
        send(8'd0, 8'd9);
        send(8'd0, 8'd0);
        drain();
        hold_left = 5;
        send(8'd40, 8'd24);
        drain();
        send(8'd255, 8'd1);
        send(8'd200, 8'd75);
        drain();

        // Abort a job mid-calculation with an asynchronous reset.
        send(8'd100, 8'd30);
        t = 0;
        while (!gcd_start && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("start_seen", {31'd0, gcd_start}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_flags", {29'd0, gcd_start, out_valid, busy}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(8'd9, 8'd6);
        drain();

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 9) == 0) hold_left = $urandom_range(1, 4);
            send(ra, rb);
        end
        drain();

`ifdef GCD_DRV_TIMEOUT_EN
        calc_hang = 1'b1;
        send(8'd21, 8'd14);
        drain();
        calc_hang = 1'b0;
        send(8'd21, 8'd14);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
